// File: rtl/writeback_retire_unit.sv
// Writeback/retire stage: formats register-file write data (including load
// alignment and extension), buffers results in a small FIFO and counts retirements.
module writeback_retire_unit #(
   parameter int REGISTER_WIDTH = 32,
   parameter int REGISTER_DEPTH = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 2,
   parameter int INSTRET_WIDTH  = 64
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          s_tvalid,
   output logic                                          s_tready,
   input  logic [6:0]                                    s_opcode,
   input  logic [2:0]                                    s_funct3,
   input  logic [$clog2(REGISTER_DEPTH)-1:0]             s_rd,
   input  logic [REGISTER_WIDTH-1:0]                     s_alu_result,
   input  logic [REGISTER_WIDTH-1:0]                     s_branch_target,
   input  logic [REGISTER_WIDTH-1:0]                     s_mem_data,
   input  logic [$clog2(REGISTER_WIDTH/BYTE_WIDTH)-1:0]  s_mem_byte_offset,
   input  logic                                          rf_ready,
   output logic                                          rf_write_enable,
   output logic [$clog2(REGISTER_DEPTH)-1:0]             rf_write_address,
   output logic [REGISTER_WIDTH-1:0]                     rf_write_data,
   output logic                                          load_misaligned,
   output logic [INSTRET_WIDTH-1:0]                      instret
);

   localparam int AW = $clog2(REGISTER_DEPTH);
   localparam int OW = $clog2(REGISTER_WIDTH/BYTE_WIDTH);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(REGISTER_WIDTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   localparam logic [6:0] OP_LOAD                 = 7'b0000011;
   localparam logic [6:0] OP_ARITHMETIC_IMMEDIATE = 7'b0010011;
   localparam logic [6:0] OP_AUIPC                = 7'b0010111;
   localparam logic [6:0] OP_ARITHMETIC           = 7'b0110011;
   localparam logic [6:0] OP_LUI                  = 7'b0110111;
   localparam logic [6:0] OP_JALR                 = 7'b1100111;
   localparam logic [6:0] OP_JAL                  = 7'b1101111;

   typedef struct packed {
      logic                      we;
      logic                      misaligned;
      logic [AW-1:0]             rd;
      logic [REGISTER_WIDTH-1:0] data;
   } entry_t;

   // Extend the low 'bits' of v; bits == REGISTER_WIDTH degenerates to passthrough.
   function automatic logic [REGISTER_WIDTH-1:0] ext(input logic [REGISTER_WIDTH-1:0] v,
                                                    input int bits, input logic sgn);
      logic        [REGISTER_WIDTH-1:0] t;
      logic signed [REGISTER_WIDTH-1:0] s;
      t = v << (REGISTER_WIDTH - bits);
      s = $signed(t) >>> (REGISTER_WIDTH - bits);
      ext = sgn ? $unsigned(s) : (t >> (REGISTER_WIDTH - bits));
   endfunction

   logic [SW-1:0]             shamt;
   logic [REGISTER_WIDTH-1:0] shifted;
   logic [REGISTER_WIDTH-1:0] load_data, sel_data;
   logic                      load_ok, load_mis, sel_we, sel_mis;
   entry_t                    push_entry, head;
   entry_t                    mem [FIFO_DEPTH];
   logic [PW-1:0]             wr_ptr, rd_ptr;
   logic [PW:0]               count, count_next;
   logic                      push, pop, empty;

   assign shamt   = SW'(int'(s_mem_byte_offset) * BYTE_WIDTH);
   assign shifted = s_mem_data >> shamt;

   always_comb begin
      load_ok   = 1'b0;
      load_mis  = 1'b0;
      load_data = '0;
      case (s_funct3)
         3'b000: begin load_ok = 1'b1; load_data = ext(shifted, BYTE_WIDTH, 1'b1); end
         3'b100: begin load_ok = 1'b1; load_data = ext(shifted, BYTE_WIDTH, 1'b0); end
         3'b001: begin
            load_ok = 1'b1; load_mis = s_mem_byte_offset[0];
            load_data = ext(shifted, 2*BYTE_WIDTH, 1'b1);
         end
         3'b101: begin
            load_ok = 1'b1; load_mis = s_mem_byte_offset[0];
            load_data = ext(shifted, 2*BYTE_WIDTH, 1'b0);
         end
         3'b010: begin
            load_ok = 1'b1; load_mis = |(s_mem_byte_offset & OW'(3));
            load_data = ext(shifted, 4*BYTE_WIDTH, 1'b1);
         end
         3'b110: if (REGISTER_WIDTH == 64) begin
            load_ok = 1'b1; load_mis = |(s_mem_byte_offset & OW'(3));
            load_data = ext(shifted, 4*BYTE_WIDTH, 1'b0);
         end
         3'b011: if (REGISTER_WIDTH == 64) begin
            load_ok = 1'b1; load_mis = |s_mem_byte_offset;
            load_data = shifted;
         end
         default: ;
      endcase
   end

   // Stores, branches, system ops and illegal loads become non-writing entries that still retire.
   always_comb begin
      sel_we   = 1'b0;
      sel_mis  = 1'b0;
      sel_data = '0;
      case (s_opcode)
         OP_ARITHMETIC, OP_ARITHMETIC_IMMEDIATE, OP_JALR, OP_LUI, OP_AUIPC: begin
            sel_we = 1'b1; sel_data = s_alu_result;
         end
         OP_JAL: begin sel_we = 1'b1; sel_data = s_branch_target; end
         OP_LOAD: begin
            sel_we = load_ok & ~load_mis; sel_mis = load_ok & load_mis; sel_data = load_data;
         end
         default: ;
      endcase
      push_entry            = '0;
      push_entry.we         = sel_we && (s_rd != '0);
      push_entry.misaligned = sel_mis;
      push_entry.rd         = push_entry.we ? s_rd : '0;
      push_entry.data       = push_entry.we ? sel_data : '0;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign push  = s_tvalid & s_tready;
   assign pop   = ~empty & (rf_ready | ~head.we);

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + 1'b1;
      else if (!push && pop) count_next = count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         s_tready <= 1'b0;
         instret  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count_next;
         s_tready <= (count_next < DEPTH_C);
         if (pop && !head.misaligned) instret <= instret + INSTRET_WIDTH'(1);
      end
   end

   // Storage needs no reset: every output is gated by the (reset) occupancy count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   assign rf_write_enable  = ~empty & head.we;
   assign rf_write_address = empty ? '0 : head.rd;
   assign rf_write_data    = empty ? '0 : head.data;
   assign load_misaligned  = ~empty & head.misaligned;

endmodule

// File: tb/tb_writeback_retire_unit.sv
// Directed bench for writeback_retire_unit: a 32-bit instance for the main
// behaviour and a 64-bit instance for wide loads and mid-operation reset.
module tb_writeback_retire_unit;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_ADD   = 7'b0110011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // 32-bit instance
   logic        rst = 1'b0, s_tvalid = 1'b0, s_tready, rf_ready = 1'b0;
   logic [6:0]  s_opcode = '0;
   logic [2:0]  s_funct3 = '0;
   logic [4:0]  s_rd = '0, rf_write_address;
   logic [31:0] s_alu_result = '0, s_branch_target = '0, s_mem_data = '0, rf_write_data;
   logic [1:0]  s_mem_byte_offset = '0;
   logic        rf_write_enable, load_misaligned;
   logic [63:0] instret;

   writeback_retire_unit dut (
      .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_opcode(s_opcode), .s_funct3(s_funct3), .s_rd(s_rd),
      .s_alu_result(s_alu_result), .s_branch_target(s_branch_target),
      .s_mem_data(s_mem_data), .s_mem_byte_offset(s_mem_byte_offset),
      .rf_ready(rf_ready), .rf_write_enable(rf_write_enable),
      .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
      .load_misaligned(load_misaligned), .instret(instret)
   );

   // 64-bit instance
   logic        rst_w = 1'b0, tvalid_w = 1'b0, tready_w, rf_ready_w = 1'b0;
   logic [6:0]  opcode_w = '0;
   logic [2:0]  funct3_w = '0;
   logic [4:0]  rd_w = '0, waddr_w;
   logic [63:0] alu_w = '0, bt_w = '0, mem_w = '0, wdata_w;
   logic [2:0]  off_w = '0;
   logic        we_w, mis_w;
   logic [63:0] instret_w;

   writeback_retire_unit #(.REGISTER_WIDTH(64)) dut64 (
      .clk(clk), .rst(rst_w), .s_tvalid(tvalid_w), .s_tready(tready_w),
      .s_opcode(opcode_w), .s_funct3(funct3_w), .s_rd(rd_w),
      .s_alu_result(alu_w), .s_branch_target(bt_w),
      .s_mem_data(mem_w), .s_mem_byte_offset(off_w),
      .rf_ready(rf_ready_w), .rf_write_enable(we_w),
      .rf_write_address(waddr_w), .rf_write_data(wdata_w),
      .load_misaligned(mis_w), .instret(instret_w)
   );

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] bt,
                        input logic [31:0] mem, input logic [1:0] off);
      s_opcode = op; s_funct3 = f3; s_rd = rd; s_alu_result = alu;
      s_branch_target = bt; s_mem_data = mem; s_mem_byte_offset = off; s_tvalid = 1'b1;
   endtask

   task automatic drive64(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [63:0] alu, input logic [63:0] mem, input logic [2:0] off);
      opcode_w = op; funct3_w = f3; rd_w = rd; alu_w = alu; mem_w = mem; off_w = off;
      tvalid_w = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b0; s_tvalid = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; s_tvalid = 1'b0; rf_ready = 1'b1;
      @(negedge clk);
      tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_tready got=%b exp=0", s_tready); end
      tests++; if (rf_write_enable !== 1'b0) begin fails++; $display("FAIL reset_we got=%b exp=0", rf_write_enable); end
      tests++; if (rf_write_address !== 5'd0) begin fails++; $display("FAIL reset_addr got=%0d exp=0", rf_write_address); end
      tests++; if (rf_write_data !== 32'd0) begin fails++; $display("FAIL reset_data got=%h exp=0", rf_write_data); end
      tests++; if (load_misaligned !== 1'b0) begin fails++; $display("FAIL reset_mis got=%b exp=0", load_misaligned); end
      tests++; if (instret !== 64'd0) begin fails++; $display("FAIL reset_instret got=%0d exp=0", instret); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL reset_tready_rise got=%b exp=1", s_tready); end
   endtask

   task automatic test_addi();
      do_reset(); rf_ready = 1'b1;
      drive(OP_IMM, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h0, 2'd0);
      @(negedge clk); s_tvalid = 1'b0;
      tests++; if (rf_write_enable !== 1'b1) begin fails++; $display("FAIL addi_we got=%b exp=1", rf_write_enable); end
      tests++; if (rf_write_address !== 5'd5) begin fails++; $display("FAIL addi_addr got=%0d exp=5", rf_write_address); end
      tests++; if (rf_write_data !== 32'h1234) begin fails++; $display("FAIL addi_data got=%h exp=1234", rf_write_data); end
      @(negedge clk);
      tests++; if (rf_write_enable !== 1'b0) begin fails++; $display("FAIL addi_drain got=%b exp=0", rf_write_enable); end
      tests++; if (instret !== 64'd1) begin fails++; $display("FAIL addi_instret got=%0d exp=1", instret); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3 [3];
      logic [1:0]  off [3];
      logic [31:0] exp [3];
      f3  = '{3'b000, 3'b100, 3'b101};
      off = '{2'd3, 2'd3, 2'd2};
      exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
      do_reset(); rf_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(OP_LOAD, f3[i], 5'd7, 32'h0, 32'h0, 32'h80FF_7F01, off[i]);
         @(negedge clk); s_tvalid = 1'b0;
         tests++; if (rf_write_enable !== 1'b1) begin fails++; $display("FAIL load%0d_we got=%b exp=1", i, rf_write_enable); end
         tests++; if (rf_write_data !== exp[i]) begin fails++; $display("FAIL load%0d_data got=%h exp=%h", i, rf_write_data, exp[i]); end
         @(negedge clk);
      end
      tests++; if (instret !== 64'd3) begin fails++; $display("FAIL load_instret got=%0d exp=3", instret); end
   endtask

   task automatic test_misaligned();
      logic [2:0] f3 [2];
      logic [1:0] off [2];
      f3  = '{3'b010, 3'b001};
      off = '{2'd2, 2'd1};
      do_reset(); rf_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(OP_LOAD, f3[i], 5'd9, 32'h0, 32'h0, 32'hDEAD_BEEF, off[i]);
         @(negedge clk); s_tvalid = 1'b0;
         tests++; if (rf_write_enable !== 1'b0) begin fails++; $display("FAIL mis%0d_we got=%b exp=0", i, rf_write_enable); end
         tests++; if (load_misaligned !== 1'b1) begin fails++; $display("FAIL mis%0d_flag got=%b exp=1", i, load_misaligned); end
         @(negedge clk);
         tests++; if (load_misaligned !== 1'b0) begin fails++; $display("FAIL mis%0d_pop got=%b exp=0", i, load_misaligned); end
      end
      tests++; if (instret !== 64'd0) begin fails++; $display("FAIL mis_instret got=%0d exp=0", instret); end
   endtask

   task automatic test_boundary();
      do_reset(); rf_ready = 1'b1;
      // LWU is illegal at 32 bits: non-writing, not misaligned, still retires
      drive(OP_LOAD, 3'b110, 5'd7, 32'h0, 32'h0, 32'h8000_0000, 2'd0);
      @(negedge clk); s_tvalid = 1'b0;
      tests++; if (rf_write_enable !== 1'b0) begin fails++; $display("FAIL lwu32_we got=%b exp=0", rf_write_enable); end
      tests++; if (load_misaligned !== 1'b0) begin fails++; $display("FAIL lwu32_mis got=%b exp=0", load_misaligned); end
      @(negedge clk);
      drive(OP_IMM, 3'b000, 5'd0, 32'h5, 32'h0, 32'h0, 2'd0);
      @(negedge clk); s_tvalid = 1'b0;
      tests++; if (rf_write_enable !== 1'b0) begin fails++; $display("FAIL rd0_we got=%b exp=0", rf_write_enable); end
      @(negedge clk);
      drive(OP_LOAD, 3'b010, 5'd3, 32'h0, 32'h0, 32'h80FF_7F01, 2'd0);
      @(negedge clk); s_tvalid = 1'b0;
      tests++; if (rf_write_data !== 32'h80FF_7F01) begin fails++; $display("FAIL lw32_data got=%h exp=80ff7f01", rf_write_data); end
      @(negedge clk);
      tests++; if (instret !== 64'd3) begin fails++; $display("FAIL boundary_instret got=%0d exp=3", instret); end
   endtask

   task automatic test_back_to_back();
      do_reset(); rf_ready = 1'b0;
      drive(OP_ADD, 3'b000, 5'd1, 32'h11, 32'h0, 32'h0, 2'd0);
      @(negedge clk);
      drive(OP_ADD, 3'b000, 5'd2, 32'h22, 32'h0, 32'h0, 2'd0);
      @(negedge clk);
      drive(OP_ADD, 3'b000, 5'd3, 32'h33, 32'h0, 32'h0, 2'd0);
      tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL b2b_full_tready got=%b exp=0", s_tready); end
      tests++; if (rf_write_address !== 5'd1) begin fails++; $display("FAIL b2b_head_addr got=%0d exp=1", rf_write_address); end
      @(negedge clk);
      tests++; if (rf_write_data !== 32'h11) begin fails++; $display("FAIL b2b_held got=%h exp=11", rf_write_data); end
      rf_ready = 1'b1;
      @(negedge clk);
      tests++; if (rf_write_data !== 32'h22) begin fails++; $display("FAIL b2b_second got=%h exp=22", rf_write_data); end
      tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL b2b_tready_rise got=%b exp=1", s_tready); end
      @(negedge clk); s_tvalid = 1'b0;
      tests++; if (rf_write_data !== 32'h33 || rf_write_address !== 5'd3) begin
         fails++; $display("FAIL b2b_third got=%h@%0d exp=33@3", rf_write_data, rf_write_address); end
      @(negedge clk);
      tests++; if (instret !== 64'd3) begin fails++; $display("FAIL b2b_instret got=%0d exp=3", instret); end
   endtask

   task automatic test_store_jal();
      do_reset(); rf_ready = 1'b0;
      drive(OP_STORE, 3'b010, 5'd4, 32'hAA, 32'h0, 32'h0, 2'd0);
      @(negedge clk);
      tests++; if (rf_write_enable !== 1'b0) begin fails++; $display("FAIL store_we got=%b exp=0", rf_write_enable); end
      drive(OP_JAL, 3'b000, 5'd1, 32'h0, 32'h100, 32'h0, 2'd0);
      @(negedge clk); s_tvalid = 1'b0;
      tests++; if (rf_write_enable !== 1'b1 || rf_write_data !== 32'h100 || rf_write_address !== 5'd1) begin
         fails++; $display("FAIL jal_head got=%b %h@%0d exp=1 100@1", rf_write_enable, rf_write_data, rf_write_address); end
      tests++; if (instret !== 64'd1) begin fails++; $display("FAIL store_retired got=%0d exp=1", instret); end
      @(negedge clk);
      tests++; if (rf_write_enable !== 1'b1 || instret !== 64'd1) begin
         fails++; $display("FAIL jal_hold got=%b/%0d exp=1/1", rf_write_enable, instret); end
      rf_ready = 1'b1;
      @(negedge clk);
      tests++; if (instret !== 64'd2 || rf_write_enable !== 1'b0) begin
         fails++; $display("FAIL jal_retire got=%0d/%b exp=2/0", instret, rf_write_enable); end
   endtask

   task automatic test_rv64();
      rst_w = 1'b0; tvalid_w = 1'b0;
      @(negedge clk); rst_w = 1'b1;
      @(negedge clk); rf_ready_w = 1'b1;
      drive64(OP_LOAD, 3'b010, 5'd9, 64'h0, 64'h0000_0000_8000_0000, 3'd0);
      @(negedge clk); tvalid_w = 1'b0;
      tests++; if (wdata_w !== 64'hFFFF_FFFF_8000_0000) begin fails++; $display("FAIL lw64_data got=%h exp=ffffffff80000000", wdata_w); end
      @(negedge clk);
      drive64(OP_LOAD, 3'b110, 5'd9, 64'h0, 64'h0000_0000_8000_0000, 3'd0);
      @(negedge clk); tvalid_w = 1'b0;
      tests++; if (wdata_w !== 64'h0000_0000_8000_0000) begin fails++; $display("FAIL lwu64_data got=%h exp=0000000080000000", wdata_w); end
      @(negedge clk);
      drive64(OP_LOAD, 3'b011, 5'd9, 64'h0, 64'h1, 3'd4);
      @(negedge clk); tvalid_w = 1'b0;
      tests++; if (mis_w !== 1'b1 || we_w !== 1'b0) begin fails++; $display("FAIL ld64_mis got=%b/%b exp=1/0", mis_w, we_w); end
      @(negedge clk);
      tests++; if (instret_w !== 64'd2) begin fails++; $display("FAIL rv64_instret got=%0d exp=2", instret_w); end
      rf_ready_w = 1'b0;
      drive64(OP_ADD, 3'b000, 5'd3, 64'h3, 64'h0, 3'd0);
      @(negedge clk);
      drive64(OP_ADD, 3'b000, 5'd4, 64'h4, 64'h0, 3'd0);
      @(negedge clk); tvalid_w = 1'b0;
      tests++; if (we_w !== 1'b1 || waddr_w !== 5'd3 || tready_w !== 1'b0) begin
         fails++; $display("FAIL rv64_buffered got=%b@%0d rdy=%b exp=1@3 rdy=0", we_w, waddr_w, tready_w); end
      #2 rst_w = 1'b0;
      #1;
      tests++; if (we_w !== 1'b0 || waddr_w !== 5'd0 || wdata_w !== 64'd0 || instret_w !== 64'd0 || tready_w !== 1'b0) begin
         fails++; $display("FAIL rv64_midreset got=%b@%0d %h cnt=%0d rdy=%b exp=all 0", we_w, waddr_w, wdata_w, instret_w, tready_w); end
      @(negedge clk); rst_w = 1'b1;
      @(negedge clk);
      tests++; if (we_w !== 1'b0 || tready_w !== 1'b1) begin
         fails++; $display("FAIL rv64_after_reset got=we%b rdy%b exp=we0 rdy1", we_w, tready_w); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_loads();
      test_misaligned();
      test_boundary();
      test_back_to_back();
      test_store_jal();
      test_rv64();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
